// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types, response codes and strobe merge for the AXI4-Lite register bank
//
// Purpose : common definitions imported by axil_regfile and its sub-module.
// Contents: resp_t / RESP_OKAY / RESP_SLVERR, buf_state_t, merge().

package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Occupancy of one AW or W holding buffer.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Widest supported data bus; merge() works on this width and callers
  // zero-extend / truncate their DATA_W-wide operands.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  // Byte k of the result comes from new_v when strb[k] is set, else from old_v.
  function automatic logic [MAX_DATA_W-1:0] merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int k = 0; k < MAX_STRB_W; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// rtl/axil_regfile_if.sv - AXI4-Lite bus bundle with master and slave modports
//
// Purpose : groups the five AXI4-Lite channels into one port.
// Ports   : AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).

interface axil_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import axil_pkg::*;

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  resp_t               bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  resp_t               rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_wr_collect.sv
// rtl/axil_wr_collect.sv - AW/W holding buffers producing a single write commit strobe
//
// Purpose : accepts AW and W in either order, holds each until the other
//           arrives, then presents commit for one cycle with decoded index.
// Ports   : aclk/arst clock and sync reset; en enables readies after reset;
//           awaddr/awvalid/awready, wdata/wstrb/wvalid/wready from the bus;
//           bvalid blocks new acceptance; commit/idx/decode_err/data/strb
//           describe the pending write to the register bank.

module axil_wr_collect
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic                en,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  input  logic                bvalid,
  output logic                commit,
  output logic [IDX_W-1:0]    idx,
  output logic                decode_err,
  output logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] strb
);

  localparam int ALSB   = $clog2(DATA_W / 8);
  localparam int WORD_W = ADDR_W - ALSB;

  buf_state_t          aw_state;
  buf_state_t          w_state;
  logic [WORD_W-1:0]   aw_word;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;

  // Byte-offset bits never select anything.
  logic unused_lsb;
  assign unused_lsb = ^awaddr[ALSB-1:0];

  assign awready = en && (aw_state == BUF_EMPTY) && !bvalid;
  assign wready  = en && (w_state == BUF_EMPTY) && !bvalid;

  // Both buffers full: the bank writes on this edge and both buffers drain.
  assign commit     = (aw_state == BUF_FULL) && (w_state == BUF_FULL);
  assign idx        = aw_word[IDX_W-1:0];
  assign decode_err = aw_word >= WORD_W'(NUM_REGS);
  assign data       = w_data_q;
  assign strb       = w_strb_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      aw_state <= BUF_EMPTY;
      w_state  <= BUF_EMPTY;
      aw_word  <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      aw_state <= BUF_EMPTY;
      w_state  <= BUF_EMPTY;
    end else begin
      if (awvalid && awready) begin
        aw_state <= BUF_FULL;
        aw_word  <= awaddr[ADDR_W-1:ALSB];
      end
      if (wvalid && wready) begin
        w_state  <= BUF_FULL;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// rtl/axil_regfile.sv - parametrised AXI4-Lite slave register bank
//
// Purpose : NUM_REGS registers of DATA_W bits behind an AXI4-Lite slave, with
//           read-only slots mapped to hardware inputs, byte-strobe merging,
//           SLVERR on decode/RO errors and per-register write pulses.
// Ports   : aclk, arst (sync active-high); s_axil AXI4-Lite slave bundle;
//           reg_out RW register contents (slice i = register i);
//           reg_in hardware values for RO registers; wr_pulse one-cycle
//           commit indication per register.

module axil_regfile
  import axil_pkg::*;
#(
  parameter int                   DATA_W    = 32,  // 32 or 64
  parameter int                   NUM_REGS  = 8,   // 1..256
  parameter int                   ADDR_W    = 32,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                         aclk,
  input  logic                         arst,
  axil_regfile_if.slave                s_axil,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int ALSB   = $clog2(STRB_W);
  localparam int WORD_W = ADDR_W - ALSB;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Holds every ready low from the reset edge until the first edge with arst low.
  logic en;

  always_ff @(posedge aclk) begin
    if (arst) begin
      en <= 1'b0;
    end else begin
      en <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- write
  logic              commit;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_decode_err;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_err;
  logic              bvalid_q;
  resp_t             bresp_q;

  axil_wr_collect #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_wr_collect (
    .aclk       (aclk),
    .arst       (arst),
    .en         (en),
    .awaddr     (s_axil.awaddr),
    .awvalid    (s_axil.awvalid),
    .awready    (s_axil.awready),
    .wdata      (s_axil.wdata),
    .wstrb      (s_axil.wstrb),
    .wvalid     (s_axil.wvalid),
    .wready     (s_axil.wready),
    .bvalid     (bvalid_q),
    .commit     (commit),
    .idx        (wr_idx),
    .decode_err (wr_decode_err),
    .data       (wr_data),
    .strb       (wr_strb)
  );

  // Decode error is tested first so RO_MASK is only consulted for in-range indices.
  assign wr_err = wr_decode_err || RO_MASK[wr_idx];

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Strobe merge runs at the widest bus width; operands are zero-extended.
  logic [MAX_DATA_W-1:0] old_wide;
  logic [MAX_DATA_W-1:0] new_wide;
  logic [MAX_STRB_W-1:0] strb_wide;
  logic [MAX_DATA_W-1:0] merged_wide;
  logic [DATA_W-1:0]     merged;

  always_comb begin
    old_wide                = '0;
    new_wide                = '0;
    strb_wide               = '0;
    old_wide[DATA_W-1:0]    = regs[wr_idx];
    new_wide[DATA_W-1:0]    = wr_data;
    strb_wide[STRB_W-1:0]   = wr_strb;
    merged_wide             = merge(old_wide, new_wide, strb_wide);
    merged                  = merged_wide[DATA_W-1:0];
  end

  logic unused_merge;
  assign unused_merge = ^merged_wide;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    // RO slots keep RESET_VAL in storage; reads of them go to reg_in instead.
    always_ff @(posedge aclk) begin
      if (arst) begin
        regs[i] <= RESET_VAL;
      end else if (commit && !wr_err && (wr_idx == IDX_W'(i))) begin
        regs[i] <= merged;
      end
    end
    assign reg_out[i*DATA_W +: DATA_W] = regs[i];
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      // commit cannot coincide with bvalid: AW/W are refused while bvalid is high.
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) begin
          wr_pulse <= NUM_REGS'(1) << wr_idx;
        end
      end else if (bvalid_q && s_axil.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axil.bvalid = bvalid_q;
  assign s_axil.bresp  = bresp_q;

  // ----------------------------------------------------------------- read
  logic [DATA_W-1:0] ro_vals [NUM_REGS];
  logic [WORD_W-1:0] rd_word;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_err;
  logic [DATA_W-1:0] rd_val;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  resp_t             rresp_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ro
    assign ro_vals[i] = reg_in[i*DATA_W +: DATA_W];
  end

  assign rd_word = s_axil.araddr[ADDR_W-1:ALSB];
  assign rd_idx  = rd_word[IDX_W-1:0];
  assign rd_err  = rd_word >= WORD_W'(NUM_REGS);
  // regs[] is sampled before any same-edge commit lands, so a colliding
  // read returns the pre-commit value.
  assign rd_val  = RO_MASK[rd_idx] ? ro_vals[rd_idx] : regs[rd_idx];

  assign s_axil.arready = en && !rvalid_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (s_axil.arvalid && s_axil.arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_err ? '0 : rd_val;
      rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s_axil.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axil.rvalid = rvalid_q;
  assign s_axil.rdata  = rdata_q;
  assign s_axil.rresp  = rresp_q;

  logic unused_bus;
  assign unused_bus = ^{s_axil.awprot, s_axil.arprot, s_axil.araddr[ALSB-1:0]};

endmodule

// File: tb/tb_axil_regfile.sv
// tb/tb_axil_regfile.sv - scoreboard testbench for axil_regfile

module tb_axil_regfile;

  logic aclk;
  logic arst;
  logic [8*32-1:0] reg_out;
  logic [8*32-1:0] reg_in;
  logic [7:0]      wr_pulse;

  axil_regfile_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_regfile #(
    .DATA_W    (32),
    .NUM_REGS  (8),
    .ADDR_W    (32),
    .RO_MASK   (8'h80),
    .RESET_VAL (32'h0)
  ) dut (
    .aclk     (aclk),
    .arst     (arst),
    .s_axil   (bus.slave),
    .reg_out  (reg_out),
    .reg_in   (reg_in),
    .wr_pulse (wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [8];

  logic [1:0]  wq [$];
  logic [33:0] rq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a B or R handshake is about to complete.
  initial for (int i = 0; i < 8; i++) pulse_cnt[i] = 0;

  always @(negedge aclk) begin
    for (int i = 0; i < 8; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    if (bus.bvalid && bus.bready) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bresp %b expected no response", bus.bresp);
      end else begin
        check("bresp", 64'(bus.bresp), 64'(wq.pop_front()));
      end
    end
    if (bus.rvalid && bus.rready) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got rdata %h expected no response", bus.rdata);
      end else begin
        check("rdata_rresp", 64'({bus.rdata, bus.rresp}), 64'(rq.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic [1:0] exp_resp, input bit wait_b);
    bit aw_done, w_done, aw_hs, w_hs;
    int n, k;
    aw_done = 0; w_done = 0; n = 0;
    wq.push_back(exp_resp);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_done && w_done) && n < 100) begin
      if (w_done && !aw_done) check("w_held_wready", 64'(bus.wready), 64'd0);
      bus.awvalid = !aw_done && (n >= aw_dly);
      bus.wvalid  = !w_done && (n >= w_dly);
      @(negedge aclk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      n++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("FAIL write_timeout: got aw %0d w %0d expected both handshakes", aw_done, w_done);
    end else begin
      check("bvalid_before_commit", 64'(bus.bvalid), 64'd0);
      tick();
      check("bvalid_after_commit", 64'(bus.bvalid), 64'd1);
      if (wait_b) begin
        k = 0;
        while (bus.bvalid && k < 20) begin tick(); k++; end
        check("bvalid_cleared", 64'(bus.bvalid), 64'd0);
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    bit hs;
    int n;
    hs = 0; n = 0;
    rq.push_back({exp_data, exp_resp});
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge aclk);
      hs = bus.arvalid && bus.arready;
      tick();
      n++;
    end
    bus.arvalid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL read_timeout: got no AR handshake expected one");
    end else begin
      check("rvalid_latency", 64'(bus.rvalid), 64'd1);
      n = 0;
      while (bus.rvalid && n < 20) begin tick(); n++; end
      check("rvalid_cleared", 64'(bus.rvalid), 64'd0);
    end
  endtask

  function automatic logic [31:0] slice(input int i);
    return reg_out[i*32 +: 32];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    arst = 1'b1;
    reg_in = '0;
    for (int i = 0; i < 7; i++) reg_in[i*32 +: 32] = 32'hDEAD0000 + 32'(i);
    reg_in[7*32 +: 32] = 32'hCAFE0001;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;

    repeat (3) tick();
    @(negedge aclk);
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    check("rst_reg2", 64'(slice(2)), 64'd0);
    arst = 1'b0;
    tick();
    check("ready_awready", 64'(bus.awready), 64'd1);
    check("ready_wready", 64'(bus.wready), 64'd1);
    check("ready_arready", 64'(bus.arready), 64'd1);

    // 1: read after reset
    do_read(32'h08, 32'h0, 2'b00);

    // 2: full-word write then read back
    do_write(32'h08, 32'h0000001F, 4'hF, 0, 0, 2'b00, 1);
    check("t2_reg2", 64'(slice(2)), 64'h1F);
    check("t2_pulse2", 64'(pulse_cnt[2]), 64'd1);
    do_read(32'h08, 32'h0000001F, 2'b00);

    // 3: partial strobes
    do_write(32'h08, 32'hAABBCCDD, 4'b0101, 0, 0, 2'b00, 1);
    check("t3_reg2", 64'(slice(2)), 64'h00BB00DD);
    check("t3_pulse2", 64'(pulse_cnt[2]), 64'd2);
    do_read(32'h08, 32'h00BB00DD, 2'b00);

    // 4: W three cycles ahead of AW
    do_write(32'h04, 32'h12345678, 4'hF, 3, 0, 2'b00, 1);
    check("t4_reg1", 64'(slice(1)), 64'h12345678);
    check("t4_pulse1", 64'(pulse_cnt[1]), 64'd1);

    // 5: decode error and RO write
    do_write(32'h20, 32'h11111111, 4'hF, 0, 0, 2'b10, 1);
    do_write(32'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 1);
    check("t5_pulses_total", 64'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]
                                  + pulse_cnt[4] + pulse_cnt[5] + pulse_cnt[6] + pulse_cnt[7]), 64'd3);
    check("t5_reg7", 64'(slice(7)), 64'd0);
    do_read(32'h20, 32'h0, 2'b10);
    do_read(32'h1C, 32'hCAFE0001, 2'b00);

    // 6: B backpressure, then reset while bvalid is pending
    bus.bready = 1'b0;
    do_write(32'h0C, 32'h00000055, 4'hF, 0, 0, 2'b00, 0);
    check("t6_reg3", 64'(slice(3)), 64'h55);
    bus.awaddr  = 32'h10;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("t6_bvalid_hold", 64'(bus.bvalid), 64'd1);
      check("t6_bresp_hold", 64'(bus.bresp), 64'd0);
      check("t6_awready_blocked", 64'(bus.awready), 64'd0);
      check("t6_wready_blocked", 64'(bus.wready), 64'd0);
      tick();
    end
    bus.awvalid = 1'b0;
    arst = 1'b1;
    tick();
    wq.delete();
    check("t6_rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("t6_rst_reg1", 64'(slice(1)), 64'd0);
    check("t6_rst_reg2", 64'(slice(2)), 64'd0);
    check("t6_rst_reg3", 64'(slice(3)), 64'd0);
    check("t6_rst_awready", 64'(bus.awready), 64'd0);
    check("t6_pulse4", 64'(pulse_cnt[4]), 64'd0);
    arst = 1'b0;
    bus.bready = 1'b1;
    tick();
    check("t6_awready_back", 64'(bus.awready), 64'd1);
    check("t6_bvalid_after", 64'(bus.bvalid), 64'd0);
    do_read(32'h0C, 32'h0, 2'b00);

    repeat (3) tick();
    check("wq_empty", 64'(wq.size()), 64'd0);
    check("rq_empty", 64'(rq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
